// File: rtl/regfile_wb_sink.sv
// Write-back register file with two bypassed read ports and a debug dump channel.
// The dump streams every register over valid/ready without ever stalling reads or writes.
module regfile_wb_sink #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_regwrite,
    input  logic [ADDR_WIDTH-1:0] i_writereg,
    input  logic [DATA_WIDTH-1:0] i_writedata,
    input  logic [ADDR_WIDTH-1:0] i_readreg1,
    input  logic [ADDR_WIDTH-1:0] i_readreg2,
    output logic [DATA_WIDTH-1:0] o_readdata1,
    output logic [DATA_WIDTH-1:0] o_readdata2,
    input  logic                  i_dump_start,
    input  logic                  i_dump_ready,
    output logic                  o_dump_valid,
    output logic [DATA_WIDTH-1:0] o_dump_data,
    output logic [ADDR_WIDTH-1:0] o_dump_index,
    output logic                  o_dump_busy,
    output logic                  o_dump_done
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } dump_state_t;

    // Storage is cleared by reset, so it is kept in flops rather than block RAM.
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Register 0 is hard-wired to zero: its writes never land and never bypass.
    logic write_hit;
    assign write_hit = i_regwrite && (i_writereg != '0);

    // Array update; entry 0 is never written so it stays at its reset value.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_hit) begin
            regs[i_writereg] <= i_writedata;
        end
    end

    // Read ports share one template: write-first bypass, otherwise the stored value.
    logic [1:0][ADDR_WIDTH-1:0] rd_addr;
    logic [1:0][DATA_WIDTH-1:0] rd_data;

    assign rd_addr[0]  = i_readreg1;
    assign rd_addr[1]  = i_readreg2;
    assign o_readdata1 = rd_data[0];
    assign o_readdata2 = rd_data[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_read_port
            assign rd_data[gi] = (write_hit && (i_writereg == rd_addr[gi]))
                               ? i_writedata
                               : regs[rd_addr[gi]];
        end
    endgenerate

    // Dump engine state
    dump_state_t           state_reg, state_next;
    logic [ADDR_WIDTH-1:0] index_reg, index_next;
    logic [DATA_WIDTH-1:0] data_reg,  data_next;
    logic                  beat_accept;

    assign beat_accept = (state_reg == SEND) && i_dump_ready;

    // Dump state, beat index and beat data registers.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_reg <= IDLE;
            index_reg <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            index_reg <= index_next;
            data_reg  <= data_next;
        end
    end

    // Next-state logic. Beats are loaded from the pre-edge array contents, and an
    // unaccepted beat holds even if its register is rewritten meanwhile.
    always_comb begin
        state_next = state_reg;
        index_next = index_reg;
        data_next  = data_reg;
        case (state_reg)
            IDLE: begin
                if (i_dump_start) begin
                    state_next = SEND;
                    index_next = '0;
                    data_next  = regs[0];
                end
            end
            SEND: begin
                if (beat_accept) begin
                    if (index_reg == LAST_INDEX) begin
                        state_next = DONE;
                    end else begin
                        index_next = index_reg + ADDR_WIDTH'(1);
                        data_next  = regs[index_reg + ADDR_WIDTH'(1)];
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign o_dump_valid = (state_reg == SEND);
    assign o_dump_busy  = (state_reg == SEND);
    assign o_dump_done  = (state_reg == DONE);
    assign o_dump_index = index_reg;
    assign o_dump_data  = data_reg;

endmodule

// File: tb/tb_regfile_wb_sink.sv
// Bench for regfile_wb_sink: stimulus queues expected read results and dump beats,
// a negedge monitor pops and compares them whenever the DUT presents them.
module tb_regfile_wb_sink;

    logic        i_clock;
    logic        i_reset;
    logic        i_regwrite;
    logic [4:0]  i_writereg;
    logic [31:0] i_writedata;
    logic [4:0]  i_readreg1;
    logic [4:0]  i_readreg2;
    logic [31:0] o_readdata1;
    logic [31:0] o_readdata2;
    logic        i_dump_start;
    logic        i_dump_ready;
    logic        o_dump_valid;
    logic [31:0] o_dump_data;
    logic [4:0]  o_dump_index;
    logic        o_dump_busy;
    logic        o_dump_done;

    regfile_wb_sink #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_regwrite   (i_regwrite),
        .i_writereg   (i_writereg),
        .i_writedata  (i_writedata),
        .i_readreg1   (i_readreg1),
        .i_readreg2   (i_readreg2),
        .o_readdata1  (o_readdata1),
        .o_readdata2  (o_readdata2),
        .i_dump_start (i_dump_start),
        .i_dump_ready (i_dump_ready),
        .o_dump_valid (o_dump_valid),
        .o_dump_data  (o_dump_data),
        .o_dump_index (o_dump_index),
        .o_dump_busy  (o_dump_busy),
        .o_dump_done  (o_dump_done)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } beat_t;

    int          errors = 0;
    int          checks = 0;
    int          done_cnt = 0;
    logic        rd_strobe = 1'b0;
    logic [63:0] rd_q [$];
    beat_t       beat_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: consumes queued expectations as the DUT presents reads and beats.
    logic        last_acc = 1'b0;
    logic        hold_valid = 1'b0;
    logic [4:0]  held_idx = '0;
    logic [31:0] held_data = '0;

    always @(negedge i_clock) begin
        if (!i_reset) begin
            last_acc   = 1'b0;
            hold_valid = 1'b0;
        end else begin
            if (rd_strobe) begin
                if (rd_q.size() == 0) begin
                    chk("rd_underflow", 32'd1, 32'd0);
                end else begin
                    logic [63:0] v;
                    v = rd_q.pop_front();
                    $display("read r%0d=%h r%0d=%h", i_readreg1, o_readdata1, i_readreg2, o_readdata2);
                    chk("rd_port1", o_readdata1, v[63:32]);
                    chk("rd_port2", o_readdata2, v[31:0]);
                end
            end
            if (o_dump_done) begin
                chk("done_after_last_beat", {31'd0, last_acc}, 32'd1);
                done_cnt++;
            end
            if (hold_valid && o_dump_valid) begin
                chk("hold_index", {27'd0, o_dump_index}, {27'd0, held_idx});
                chk("hold_data", o_dump_data, held_data);
            end
            if (o_dump_valid && i_dump_ready) begin
                if (beat_q.size() == 0) begin
                    chk("beat_underflow", 32'd1, 32'd0);
                end else begin
                    beat_t b;
                    b = beat_q.pop_front();
                    $display("beat idx=%0d data=%h", o_dump_index, o_dump_data);
                    chk("beat_index", {27'd0, o_dump_index}, {27'd0, b.idx});
                    chk("beat_data", o_dump_data, b.data);
                end
            end
            last_acc   = o_dump_valid && i_dump_ready && (o_dump_index == 5'd31);
            hold_valid = o_dump_valid && !i_dump_ready;
            held_idx   = o_dump_index;
            held_data  = o_dump_data;
        end
    end

    // Advance one cycle; inputs change 1 time unit after the edge.
    task automatic step();
        @(posedge i_clock);
        #1;
        rd_strobe    = 1'b0;
        i_regwrite   = 1'b0;
        i_dump_start = 1'b0;
    endtask

    task automatic expect_rd(input logic [4:0] r1, input logic [4:0] r2,
                             input logic [31:0] e1, input logic [31:0] e2);
        i_readreg1 = r1;
        i_readreg2 = r2;
        rd_q.push_back({e1, e2});
        rd_strobe = 1'b1;
    endtask

    task automatic write_reg(input logic [4:0] r, input logic [31:0] d);
        i_regwrite  = 1'b1;
        i_writereg  = r;
        i_writedata = d;
    endtask

    // Counts negedges until done is seen; exp_n is the expected count.
    task automatic wait_done(input string nm, input int exp_n);
        int n;
        n = 0;
        while (n < 200) begin
            @(negedge i_clock);
            n++;
            if (o_dump_done) break;
        end
        if (n >= 200) chk({nm, "_timeout"}, 32'd1, 32'd0);
        else          chk(nm, n, exp_n);
    endtask

    task automatic start_dump();
        i_dump_start = 1'b1;
        step();
    endtask

    task automatic check_after_done(input int exp_done);
        step();
        chk("done_one_cycle", {31'd0, o_dump_done}, 32'd0);
        chk("idle_after_done", {31'd0, o_dump_busy}, 32'd0);
        chk("done_count", done_cnt, exp_done);
    endtask

    logic [31:0] rv [32];

    initial begin
        i_reset      = 1'b0;
        i_regwrite   = 1'b0;
        i_writereg   = '0;
        i_writedata  = '0;
        i_readreg1   = '0;
        i_readreg2   = '0;
        i_dump_start = 1'b0;
        i_dump_ready = 1'b0;

        repeat (3) @(posedge i_clock);
        #1;
        chk("rst_valid", {31'd0, o_dump_valid}, 32'd0);
        chk("rst_busy",  {31'd0, o_dump_busy},  32'd0);
        chk("rst_done",  {31'd0, o_dump_done},  32'd0);
        chk("rst_index", {27'd0, o_dump_index}, 32'd0);
        chk("rst_data",  o_dump_data,           32'd0);
        i_reset = 1'b1;
        step();

        // All registers read zero after reset.
        for (int i = 0; i < 32; i++) begin
            expect_rd(5'(i), 5'(31 - i), 32'd0, 32'd0);
            step();
        end

        // Write-first bypass on r5 and dropped writes to r0.
        write_reg(5'd5, 32'hDEADBEEF);
        expect_rd(5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);
        step();
        expect_rd(5'd5, 5'd0, 32'hDEADBEEF, 32'd0);
        step();
        write_reg(5'd0, 32'h00001234);
        expect_rd(5'd0, 5'd5, 32'd0, 32'hDEADBEEF);
        step();
        expect_rd(5'd0, 5'd5, 32'd0, 32'hDEADBEEF);
        step();

        // Dual port: r3 stored, r7 bypassed in its write cycle, then both stored.
        write_reg(5'd3, 32'h0000000A);
        step();
        write_reg(5'd7, 32'h0000000B);
        expect_rd(5'd3, 5'd7, 32'h0000000A, 32'h0000000B);
        step();
        expect_rd(5'd3, 5'd7, 32'h0000000A, 32'h0000000B);
        step();

        // Fill regs[i] = 4*i.
        for (int i = 0; i < 32; i++) rv[i] = 32'(4 * i);
        for (int i = 1; i < 32; i++) begin
            write_reg(5'(i), rv[i]);
            step();
        end

        // Full dump with ready held high.
        for (int i = 0; i < 32; i++) beat_q.push_back('{idx: 5'(i), data: rv[i]});
        i_dump_ready = 1'b1;
        start_dump();
        wait_done("full_dump_latency", 33);
        check_after_done(1);

        // Back-pressure on beat 10 while r10 and r11 are rewritten.
        for (int i = 0; i < 32; i++) begin
            beat_q.push_back('{idx: 5'(i), data: (i == 11) ? 32'h00005555 : rv[i]});
        end
        start_dump();
        repeat (10) step();
        i_dump_ready = 1'b0;
        write_reg(5'd10, 32'h0000FFFF);
        step();
        write_reg(5'd11, 32'h00005555);
        step();
        step();
        chk("bp_index_held", {27'd0, o_dump_index}, 32'd10);
        chk("bp_data_old", o_dump_data, 32'd40);
        i_dump_ready = 1'b1;
        wait_done("bp_dump_tail", 23);
        check_after_done(2);

        // Re-dump reflects the writes.
        rv[10] = 32'h0000FFFF;
        rv[11] = 32'h00005555;
        for (int i = 0; i < 32; i++) beat_q.push_back('{idx: 5'(i), data: rv[i]});
        start_dump();
        wait_done("redump_latency", 33);
        check_after_done(3);

        // Reset at beat 15: abandon immediately, no done pulse.
        for (int i = 0; i < 16; i++) beat_q.push_back('{idx: 5'(i), data: rv[i]});
        start_dump();
        repeat (15) step();
        @(negedge i_clock);
        #2;
        i_reset = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, o_dump_valid}, 32'd0);
        chk("mid_rst_busy",  {31'd0, o_dump_busy},  32'd0);
        chk("mid_rst_index", {27'd0, o_dump_index}, 32'd0);
        chk("mid_rst_data",  o_dump_data,           32'd0);
        repeat (3) @(posedge i_clock);
        #1;
        i_reset = 1'b1;
        chk("mid_rst_no_done", done_cnt, 32'd3);
        chk("mid_rst_beats_left", beat_q.size(), 32'd0);
        expect_rd(5'd10, 5'd11, 32'd0, 32'd0);
        step();

        // New dump after reset starts at index 0 with cleared contents.
        for (int i = 0; i < 32; i++) beat_q.push_back('{idx: 5'(i), data: 32'd0});
        start_dump();
        wait_done("post_rst_dump", 33);
        check_after_done(4);

        chk("beat_q_empty", beat_q.size(), 32'd0);
        chk("rd_q_empty", rd_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
